// File: rtl/expr_lane_pkg.sv
// Shared types for the expression lane pipeline: opcode enum, per-lane operand
// bundle and the context-width helper.
package expr_lane_pkg;

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_MUL     = 4'd2,
        OP_DIV     = 4'd3,
        OP_MOD     = 4'd4,
        OP_AND     = 4'd5,
        OP_OR      = 4'd6,
        OP_XOR     = 4'd7,
        OP_XNOR    = 4'd8,
        OP_SHL     = 4'd9,
        OP_SHR     = 4'd10,
        OP_ASHR    = 4'd11,
        OP_LT      = 4'd12,
        OP_EQ      = 4'd13,
        OP_RED_XOR = 4'd14,
        OP_RED_OR  = 4'd15
    } op_e;

    // Operand slots are sized for the widest supported lane; lanes use the low bits.
    localparam int OPND_W = 16;

    typedef struct packed {
        op_e               op;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic              a_sgn;
        logic              b_sgn;
    } lane_opnd_t;

    function automatic int ctx_w(input int wa, input int wb, input int wy);
        int m;
        m = (wa > wb) ? wa : wb;
        return (m > wy) ? m : wy;
    endfunction

endpackage

// File: rtl/expr_lane_pipe_if.sv
// Handshake bundle between the stimulus side (master) and the lane pipeline (slave).
interface expr_lane_pipe_if #(
    parameter int WA    = 6,
    parameter int WB    = 6,
    parameter int WY    = 8,
    parameter int LANES = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*LANES-1:0]    in_op;
    logic [WA*LANES-1:0]   in_a;
    logic [WB*LANES-1:0]   in_b;
    logic [LANES-1:0]      in_a_sgn;
    logic [LANES-1:0]      in_b_sgn;
    logic                  out_valid;
    logic                  out_ready;
    logic [WY*LANES-1:0]   out_y;
    logic [LANES-1:0]      out_dz;
    logic [15:0]           txn_cnt;

    modport master (
        output in_valid, in_op, in_a, in_b, in_a_sgn, in_b_sgn, out_ready,
        input  in_ready, out_valid, out_y, out_dz, txn_cnt
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_a_sgn, in_b_sgn, out_ready,
        output in_ready, out_valid, out_y, out_dz, txn_cnt
    );
endinterface

// File: rtl/expr_lane_alu.sv
// Combinational single-lane evaluator with Verilog mixed-signedness semantics.
// EXPR_LANE_SAT_EN: ADD/SUB/MUL saturate to the WY range instead of truncating.
module expr_lane_alu
    import expr_lane_pkg::*;
#(
    parameter int WA = 6,
    parameter int WB = 6,
    parameter int WY = 8
) (
    input  lane_opnd_t    opnd,
    output logic [WY-1:0] y,
    output logic          dz
);
    localparam int CW = ctx_w(WA, WB, WY);
    localparam int XW = 2 * CW + 2;

    logic                 sgn;
    logic                 arith;
    logic [WA-1:0]        ar;
    logic [WB-1:0]        br;
    logic [CW-1:0]        ax, bx, res;
    logic signed [XW-1:0] aw, bw, wide;
    logic                 unused_hi;

    assign sgn = opnd.a_sgn & opnd.b_sgn;
    assign ar  = opnd.a[WA-1:0];
    assign br  = opnd.b[WB-1:0];
    assign ax  = sgn ? CW'($signed(ar)) : CW'(ar);
    assign bx  = sgn ? CW'($signed(br)) : CW'(br);
    // Arithmetic runs wider than the context so saturation sees the true value.
    assign aw  = sgn ? XW'($signed(ax)) : XW'(ax);
    assign bw  = sgn ? XW'($signed(bx)) : XW'(bx);
    assign unused_hi = ^{opnd.a[OPND_W-1:WA], opnd.b[OPND_W-1:WB]};

`ifdef EXPR_LANE_SAT_EN
    localparam logic signed [XW-1:0] SMAX = (XW'(1) <<< (WY - 1)) - XW'(1);
    localparam logic signed [XW-1:0] SMIN = -(XW'(1) <<< (WY - 1));
    localparam logic signed [XW-1:0] UMAX = (XW'(1) <<< WY) - XW'(1);
`else
    logic unused_wide;
    assign unused_wide = ^{wide[XW-1:CW], arith};
`endif

    always_comb begin
        wide  = '0;
        res   = '0;
        dz    = 1'b0;
        arith = 1'b0;
        case (opnd.op)
            OP_ADD:  begin wide = aw + bw; res = wide[CW-1:0]; arith = 1'b1; end
            OP_SUB:  begin wide = aw - bw; res = wide[CW-1:0]; arith = 1'b1; end
            OP_MUL:  begin wide = aw * bw; res = wide[CW-1:0]; arith = 1'b1; end
            OP_DIV:  if (bx == '0) dz = 1'b1;
                     else begin wide = aw / bw; res = wide[CW-1:0]; end
            OP_MOD:  if (bx == '0) dz = 1'b1;
                     else begin wide = aw % bw; res = wide[CW-1:0]; end
            OP_AND:  res = ax & bx;
            OP_OR:   res = ax | bx;
            OP_XOR:  res = ax ^ bx;
            OP_XNOR: res = ~(ax ^ bx);
            OP_SHL:  res = ax << br;
            OP_SHR:  res = ax >> br;
            OP_ASHR: res = sgn ? CW'($signed(ax) >>> br) : (ax >> br);
            OP_LT:   res = CW'(sgn ? ($signed(ax) < $signed(bx)) : (ax < bx));
            OP_EQ:   res = CW'(ax == bx);
            // Reductions are self-determined: they see only the raw a bits.
            OP_RED_XOR: res = CW'(^ar);
            OP_RED_OR:  res = CW'(|ar);
            default: res = '0;
        endcase
        y = res[WY-1:0];
`ifdef EXPR_LANE_SAT_EN
        if (arith) begin
            if (sgn) begin
                if (wide > SMAX)      y = SMAX[WY-1:0];
                else if (wide < SMIN) y = SMIN[WY-1:0];
            end else begin
                if (wide < 0)         y = '0;
                else if (wide > UMAX) y = UMAX[WY-1:0];
            end
        end
`endif
    end

endmodule

// File: rtl/expr_lane_pipe.sv
// Two-stage LANES-wide expression pipeline with valid/ready on both sides.
// Build option EXPR_LANE_SAT_EN selects saturating ADD/SUB/MUL in every lane.
module expr_lane_pipe
    import expr_lane_pkg::*;
#(
    parameter int WA    = 6,
    parameter int WB    = 6,
    parameter int WY    = 8,
    parameter int LANES = 3
) (
    input logic            clk,
    input logic            rst_n,
    expr_lane_pipe_if.slave bus
);
    localparam int STAGES = 2;

    logic [STAGES:1]           vld_pipe;
    lane_opnd_t [LANES-1:0]    s1_d, s1_q;
    logic [LANES-1:0][WY-1:0]  alu_y;
    logic [LANES-1:0]          alu_dz;
    logic [WY*LANES-1:0]       y_d, y_q;
    logic [LANES-1:0]          dz_d, dz_q;
    logic [15:0]               cnt_q;
    logic                      s1_adv, s2_adv, acc;

    // A stage may load when empty or when its content moves on this cycle.
    assign s2_adv = !vld_pipe[2] || bus.out_ready;
    assign s1_adv = !vld_pipe[1] || s2_adv;
    assign acc    = bus.in_valid && s1_adv;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = vld_pipe[2];
    assign bus.out_y     = y_q;
    assign bus.out_dz    = dz_q;
    assign bus.txn_cnt   = cnt_q;

    // Lane l lives in slot LANES-1-l of every packed bus (lane 0 at the MSBs).
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int H = LANES - 1 - l;
        assign s1_d[l] = '{op:    op_e'(bus.in_op[H*4 +: 4]),
                           a:     OPND_W'(bus.in_a[H*WA +: WA]),
                           b:     OPND_W'(bus.in_b[H*WB +: WB]),
                           a_sgn: bus.in_a_sgn[H],
                           b_sgn: bus.in_b_sgn[H]};
        expr_lane_alu #(.WA(WA), .WB(WB), .WY(WY)) u_alu (
            .opnd (s1_q[l]),
            .y    (alu_y[l]),
            .dz   (alu_dz[l])
        );
        assign y_d[H*WY +: WY] = alu_y[l];
        assign dz_d[H]         = alu_dz[l];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            y_q      <= '0;
            dz_q     <= '0;
            cnt_q    <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= bus.in_valid;
                if (acc) s1_q <= s1_d;
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    y_q  <= y_d;
                    dz_q <= dz_d;
                end
            end
            if (acc) cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule
